// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one combinational-read instruction ROM between
// the fetch stage and a load port, with registered responses and a stall counter.
module imem_arbiter #(
    parameter int REG_BITS  = 32,
    parameter int ADDR_BITS = 15,
    parameter int CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_req,
    input  logic [REG_BITS-1:0] fetch_addr,
    output logic                fetch_gnt,
    output logic                fetch_rvalid,
    output logic                fetch_err,
    input  logic                ld_req,
    input  logic [REG_BITS-1:0] ld_addr,
    output logic                ld_gnt,
    output logic                ld_rvalid,
    output logic                ld_err,
    output logic [REG_BITS-1:0] rdata,
    output logic [REG_BITS-1:0] mem_A,
    input  logic [REG_BITS-1:0] mem_RD,
    output logic [CNT_BITS-1:0] stall_cnt
);

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_LOAD  = 1'b1
    } port_e;

    port_e                r_lastGnt;
    port_e                w_lastGntNext;
    logic                 w_fetchGnt;
    logic                 w_ldGnt;
    logic                 w_anyGnt;
    logic                 w_err;
    logic                 w_stall;
    logic [REG_BITS-1:0]  w_addr;
    logic [ADDR_BITS-1:0] w_memIdx;
    logic [ADDR_BITS-1:0] r_memIdx;
    logic [REG_BITS-1:0]  r_rdata;
    logic                 r_fetchRvalid;
    logic                 r_fetchErr;
    logic                 r_ldRvalid;
    logic                 r_ldErr;
    logic [CNT_BITS-1:0]  r_stallCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastGnt <= PORT_LOAD;
        end else begin
            r_lastGnt <= w_lastGntNext;
        end
    end

    // On a conflict the port that did not win last time gets the ROM.
    always_comb begin
        w_fetchGnt    = 1'b0;
        w_ldGnt       = 1'b0;
        w_lastGntNext = r_lastGnt;
        if (!reset) begin
            if (fetch_req && (!ld_req || r_lastGnt == PORT_LOAD)) begin
                w_fetchGnt    = 1'b1;
                w_lastGntNext = PORT_FETCH;
            end else if (ld_req) begin
                w_ldGnt       = 1'b1;
                w_lastGntNext = PORT_LOAD;
            end
        end
    end

    assign w_anyGnt = w_fetchGnt | w_ldGnt;
    assign w_addr   = w_fetchGnt ? fetch_addr : ld_addr;
    assign w_err    = (|w_addr[1:0]) | (|w_addr[REG_BITS-1:ADDR_BITS+2]);
    assign w_stall  = (fetch_req & ~w_fetchGnt) | (ld_req & ~w_ldGnt);

    // Idle cycles keep presenting the previous index so the ROM address never toggles needlessly.
    assign w_memIdx = w_anyGnt ? w_addr[ADDR_BITS+1:2] : r_memIdx;
    assign mem_A    = {{(REG_BITS-ADDR_BITS){1'b0}}, w_memIdx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memIdx      <= '0;
            r_rdata       <= '0;
            r_fetchRvalid <= 1'b0;
            r_fetchErr    <= 1'b0;
            r_ldRvalid    <= 1'b0;
            r_ldErr       <= 1'b0;
        end else begin
            r_memIdx      <= w_memIdx;
            r_fetchRvalid <= w_fetchGnt;
            r_fetchErr    <= w_fetchGnt & w_err;
            r_ldRvalid    <= w_ldGnt;
            r_ldErr       <= w_ldGnt & w_err;
            if (w_anyGnt) begin
                r_rdata <= w_err ? '0 : mem_RD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCnt <= '0;
        end else if (w_stall && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_BITS'(1);
        end
    end

    assign fetch_gnt    = w_fetchGnt;
    assign ld_gnt       = w_ldGnt;
    assign fetch_rvalid = r_fetchRvalid;
    assign fetch_err    = r_fetchErr;
    assign ld_rvalid    = r_ldRvalid;
    assign ld_err       = r_ldErr;
    assign rdata        = r_rdata;
    assign stall_cnt    = r_stallCnt;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter; the ROM model returns 0xA0000000 + word index.
module tb_imem_arbiter;

   logic        clk;
   logic        reset;
   logic        fetchReq;
   logic [31:0] fetchAddr;
   logic        ldReq;
   logic [31:0] ldAddr;
   logic        fetchGnt, fetchRvalid, fetchErr;
   logic        ldGnt, ldRvalid, ldErr;
   logic [31:0] rdata, memA, memRD;
   logic [15:0] stallCnt;

   logic        sFetchReq;
   logic        sLdReq;
   logic        sFetchGnt, sFetchRvalid, sFetchErr;
   logic        sLdGnt, sLdRvalid, sLdErr;
   logic [31:0] sRdata, sMemA, sMemRD;
   logic [1:0]  sStallCnt;

   int checks;
   int failures;

   // Main instance with default parameters.
   imem_arbiter dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetchReq), .fetch_addr(fetchAddr), .fetch_gnt(fetchGnt),
      .fetch_rvalid(fetchRvalid), .fetch_err(fetchErr),
      .ld_req(ldReq), .ld_addr(ldAddr), .ld_gnt(ldGnt),
      .ld_rvalid(ldRvalid), .ld_err(ldErr),
      .rdata(rdata), .mem_A(memA), .mem_RD(memRD), .stall_cnt(stallCnt)
   );

   // Second instance with a 2-bit stall counter to reach saturation quickly.
   imem_arbiter #(.CNT_BITS(2)) dutSmall (
      .clk(clk), .reset(reset),
      .fetch_req(sFetchReq), .fetch_addr(32'h0), .fetch_gnt(sFetchGnt),
      .fetch_rvalid(sFetchRvalid), .fetch_err(sFetchErr),
      .ld_req(sLdReq), .ld_addr(32'h4), .ld_gnt(sLdGnt),
      .ld_rvalid(sLdRvalid), .ld_err(sLdErr),
      .rdata(sRdata), .mem_A(sMemA), .mem_RD(sMemRD), .stall_cnt(sStallCnt)
   );

   // Combinational ROM models.
   assign memRD  = 32'hA000_0000 + memA;
   assign sMemRD = 32'hA000_0000 + sMemA;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Holds reset for two edges and releases it on a falling edge with all requests idle.
   task automatic applyReset();
      reset     = 1'b1;
      fetchReq  = 1'b0;
      ldReq     = 1'b0;
      sFetchReq = 1'b0;
      sLdReq    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Outputs must be cleared and grants suppressed while reset is high, even with requests present.
   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      fetchReq  = 1'b1; fetchAddr = 32'h8;
      ldReq     = 1'b1; ldAddr    = 32'h4;
      #1;
      checks++; if (fetchGnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_fetch_gnt got=%0b exp=0", fetchGnt); end
      checks++; if (ldGnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_ld_gnt got=%0b exp=0", ldGnt); end
      checks++; if (memA !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_A got=%h exp=0", memA); end
      @(posedge clk); #1;
      checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata); end
      checks++; if ({fetchRvalid, ldRvalid, fetchErr, ldErr} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {fetchRvalid, ldRvalid, fetchErr, ldErr}); end
      checks++; if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_stall got=%0d exp=0", stallCnt); end
      @(negedge clk);
      fetchReq = 1'b0; ldReq = 1'b0;
      reset = 1'b0;
   endtask

   // A lone fetch is granted immediately and answered one edge later; idle cycles hold rdata and mem_A.
   task automatic test_single_fetch();
      @(negedge clk);
      fetchReq = 1'b1; fetchAddr = 32'h8;
      #1;
      checks++; if (fetchGnt !== 1'b1) begin failures++; $display("[TB] FAIL single_fetch_gnt got=%0b exp=1", fetchGnt); end
      checks++; if (ldGnt !== 1'b0) begin failures++; $display("[TB] FAIL single_ld_gnt got=%0b exp=0", ldGnt); end
      checks++; if (memA !== 32'd2) begin failures++; $display("[TB] FAIL single_mem_A got=%h exp=2", memA); end
      @(posedge clk); #1;
      checks++; if (fetchRvalid !== 1'b1) begin failures++; $display("[TB] FAIL single_fetch_rvalid got=%0b exp=1", fetchRvalid); end
      checks++; if (rdata !== 32'hA000_0002) begin failures++; $display("[TB] FAIL single_rdata got=%h exp=a0000002", rdata); end
      checks++; if (fetchErr !== 1'b0) begin failures++; $display("[TB] FAIL single_fetch_err got=%0b exp=0", fetchErr); end
      checks++; if (ldRvalid !== 1'b0) begin failures++; $display("[TB] FAIL single_ld_rvalid got=%0b exp=0", ldRvalid); end
      @(negedge clk);
      fetchReq = 1'b0; fetchAddr = 32'h40;
      #1;
      checks++; if (memA !== 32'd2) begin failures++; $display("[TB] FAIL idle_mem_A_hold got=%h exp=2", memA); end
      @(posedge clk); #1;
      checks++; if (fetchRvalid !== 1'b0) begin failures++; $display("[TB] FAIL idle_fetch_rvalid got=%0b exp=0", fetchRvalid); end
      checks++; if (rdata !== 32'hA000_0002) begin failures++; $display("[TB] FAIL idle_rdata_hold got=%h exp=a0000002", rdata); end
      checks++; if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL single_stall got=%0d exp=0", stallCnt); end
   endtask

   // Continuous dual requests after reset alternate F,L,F,L with one stall counted per cycle.
   task automatic test_back_to_back();
      logic expFetch;
      applyReset();
      @(negedge clk);
      fetchReq = 1'b1; fetchAddr = 32'h0;
      ldReq    = 1'b1; ldAddr    = 32'h4;
      for (int i = 0; i < 4; i++) begin
         expFetch = (i % 2 == 0);
         #1;
         checks++; if ({fetchGnt, ldGnt} !== {expFetch, !expFetch}) begin failures++; $display("[TB] FAIL b2b_gnt[%0d] got=%b exp=%b", i, {fetchGnt, ldGnt}, {expFetch, !expFetch}); end
         @(posedge clk); #1;
         checks++; if ({fetchRvalid, ldRvalid} !== {expFetch, !expFetch}) begin failures++; $display("[TB] FAIL b2b_rvalid[%0d] got=%b exp=%b", i, {fetchRvalid, ldRvalid}, {expFetch, !expFetch}); end
         checks++; if (rdata !== (expFetch ? 32'hA000_0000 : 32'hA000_0001)) begin failures++; $display("[TB] FAIL b2b_rdata[%0d] got=%h exp=%h", i, rdata, expFetch ? 32'hA000_0000 : 32'hA000_0001); end
         checks++; if (stallCnt !== 16'(i + 1)) begin failures++; $display("[TB] FAIL b2b_stall[%0d] got=%0d exp=%0d", i, stallCnt, i + 1); end
         @(negedge clk);
      end
      fetchReq = 1'b0; ldReq = 1'b0;
   endtask

   // Misaligned and out-of-range loads return an error with zero data; the top in-range word does not.
   task automatic test_errors();
      @(negedge clk);
      ldReq = 1'b1; ldAddr = 32'h6;
      #1;
      checks++; if (ldGnt !== 1'b1) begin failures++; $display("[TB] FAIL misalign_gnt got=%0b exp=1", ldGnt); end
      @(posedge clk); #1;
      checks++; if ({ldRvalid, ldErr, fetchRvalid} !== 3'b110) begin failures++; $display("[TB] FAIL misalign_flags got=%b exp=110", {ldRvalid, ldErr, fetchRvalid}); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL misalign_rdata got=%h exp=0", rdata); end
      @(negedge clk);
      ldAddr = 32'h0002_0000;
      #1;
      checks++; if (memA !== 32'h0) begin failures++; $display("[TB] FAIL range_mem_A got=%h exp=0", memA); end
      @(posedge clk); #1;
      checks++; if ({ldRvalid, ldErr} !== 2'b11) begin failures++; $display("[TB] FAIL range_flags got=%b exp=11", {ldRvalid, ldErr}); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL range_rdata got=%h exp=0", rdata); end
      @(negedge clk);
      ldReq = 1'b0;
      fetchReq = 1'b1; fetchAddr = 32'h0001_FFFC;
      #1;
      checks++; if (memA !== 32'h0000_7FFF) begin failures++; $display("[TB] FAIL top_mem_A got=%h exp=7fff", memA); end
      @(posedge clk); #1;
      checks++; if ({fetchRvalid, fetchErr, ldRvalid, ldErr} !== 4'b1000) begin failures++; $display("[TB] FAIL top_flags got=%b exp=1000", {fetchRvalid, fetchErr, ldRvalid, ldErr}); end
      checks++; if (rdata !== 32'hA000_7FFF) begin failures++; $display("[TB] FAIL top_rdata got=%h exp=a0007fff", rdata); end
      @(negedge clk);
      fetchReq = 1'b0;
   endtask

   // Reset between a grant and its response edge drops the response; the next conflict goes to fetch.
   task automatic test_reset_mid();
      @(negedge clk);
      ldReq = 1'b1; ldAddr = 32'h4;
      @(negedge clk);
      ldReq = 1'b0;
      fetchReq = 1'b1; fetchAddr = 32'h8;
      #1;
      checks++; if (fetchGnt !== 1'b1) begin failures++; $display("[TB] FAIL mid_fetch_gnt got=%0b exp=1", fetchGnt); end
      #1;
      reset = 1'b1;
      #1;
      checks++; if ({fetchGnt, ldGnt, fetchRvalid, ldRvalid} !== 4'b0000) begin failures++; $display("[TB] FAIL mid_async_flags got=%b exp=0000", {fetchGnt, ldGnt, fetchRvalid, ldRvalid}); end
      checks++; if ({rdata, memA} !== 64'h0) begin failures++; $display("[TB] FAIL mid_async_data got=%h/%h exp=0/0", rdata, memA); end
      checks++; if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL mid_async_stall got=%0d exp=0", stallCnt); end
      @(posedge clk); #1;
      checks++; if ({fetchRvalid, fetchErr} !== 2'b00) begin failures++; $display("[TB] FAIL mid_no_rvalid got=%b exp=00", {fetchRvalid, fetchErr}); end
      @(negedge clk);
      ldReq = 1'b1; ldAddr = 32'h4;
      reset = 1'b0;
      #1;
      checks++; if ({fetchGnt, ldGnt} !== 2'b10) begin failures++; $display("[TB] FAIL mid_first_conflict got=%b exp=10", {fetchGnt, ldGnt}); end
      @(posedge clk); #1;
      checks++; if (rdata !== 32'hA000_0002) begin failures++; $display("[TB] FAIL mid_after_rdata got=%h exp=a0000002", rdata); end
      @(negedge clk);
      fetchReq = 1'b0; ldReq = 1'b0;
   endtask

   // With a 2-bit counter, six conflicting cycles read 1,2,3,3,3,3.
   task automatic test_stall_saturation();
      logic [1:0] expCnt [6];
      expCnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      applyReset();
      @(negedge clk);
      sFetchReq = 1'b1; sLdReq = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checks++; if (sStallCnt !== expCnt[i]) begin failures++; $display("[TB] FAIL sat_stall[%0d] got=%0d exp=%0d", i, sStallCnt, expCnt[i]); end
      end
      @(negedge clk);
      sFetchReq = 1'b0; sLdReq = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      fetchReq  = 1'b0; fetchAddr = 32'h0;
      ldReq     = 1'b0; ldAddr    = 32'h0;
      sFetchReq = 1'b0; sLdReq    = 1'b0;
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      test_stall_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port, combinational-read instruction ROM between two requesters: the fetch stage and a load port. The load port serves loads from read-only data and debug reads.
- Grants at most one access per cycle with round-robin fairness.
- Registers the read data and returns it one cycle after grant.
- Sits between the core's fetch/load logic and the instruction memory's word-indexed address/read-data pair. Flags misaligned and out-of-range accesses.

Parameters:
- REG_BITS, 32, width of addresses and data words.
- ADDR_BITS, 15, log2 of ROM depth in words. ROM holds 2**ADDR_BITS words.
- CNT_BITS, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch requests a read.
- fetch_addr  in  REG_BITS  fetch byte address.
- fetch_gnt  out  1  fetch request accepted this cycle.
- fetch_rvalid  out  1  fetch response valid, one-cycle pulse.
- fetch_err  out  1  fetch response is an error; qualified by fetch_rvalid.
- ld_req  in  1  load port requests a read.
- ld_addr  in  REG_BITS  load byte address.
- ld_gnt  out  1  load request accepted this cycle.
- ld_rvalid  out  1  load response valid, one-cycle pulse.
- ld_err  out  1  load response is an error; qualified by ld_rvalid.
- rdata  out  REG_BITS  response data, shared by both ports, qualified by the rvalids.
- mem_A  out  REG_BITS  word index to the ROM.
- mem_RD  in  REG_BITS  ROM read data, combinational from mem_A.
- stall_cnt  out  CNT_BITS  saturating count of cycles in which a request was refused.

Behaviour:
- **Reset:** asynchronous, active-high.
  - Clears rdata, both rvalids, both errs and stall_cnt to 0.
  - Sets last_gnt to LOAD.
  - While reset is high, fetch_gnt and ld_gnt are forced to 0 and mem_A is 0.
  - Reset mid-transaction drops any pending response; no rvalid follows.
- **Arbitration:** combinational, same cycle.
  - Only one req high: that port is granted.
  - Both high: grant the port that is not last_gnt. First conflict after reset therefore goes to fetch.
  - last_gnt updates on every grant to the granted port.
  - At most one gnt is high per cycle.
- **Request rules:**
  - A requester holds req and addr stable until it sees gnt.
  - The arbiter does not latch ungranted requests.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- **Address mapping:** mem_A = zero-extended winner_addr[ADDR_BITS+1:2]. With no grant, mem_A holds the last granted index (no spurious toggling).
- **Error check** on the granted address, evaluated in the grant cycle:
  - Error if addr[1:0] != 0 (misaligned).
  - Error if any bit of addr[REG_BITS-1:ADDR_BITS+2] is set (out of range).
- **Response:** latency 1.
  - On the edge after a grant, rdata <= (err ? 0 : mem_RD).
  - The granted port's rvalid <= 1 and its err <= err.
  - The other port's rvalid and err <= 0.
  - With no grant, both rvalids <= 0 and rdata holds its value.
- **Throughput:** one access per cycle sustained. Under continuous dual requests, grants alternate fetch/load.
- **stall_cnt:**
  - Increments by 1 on each cycle in which (fetch_req & !fetch_gnt) | (ld_req & !ld_gnt).
  - Counts at most 1 per cycle.
  - Saturates at 2**CNT_BITS-1 with no wrap.
  - Cleared only by reset.

Test Plan:
- Reset, then fetch_req=1 with fetch_addr=0x8 alone → fetch_gnt=1 same cycle, mem_A=2; next cycle fetch_rvalid=1, rdata=mem[2], fetch_err=0, ld_rvalid=0.
- Both req held 4 cycles, fetch_addr=0x0, ld_addr=0x4 → grants F,L,F,L; rvalids follow one cycle later with rdata mem[0],mem[1],mem[0],mem[1]; stall_cnt=4.
- ld_addr=0x6 (misaligned), then ld_addr=0x0002_0000 (out of range for ADDR_BITS=15) → each granted; ld_rvalid=1, ld_err=1, rdata=0.
- Fetch granted at cycle N, reset asserted asynchronously before edge N+1 → no fetch_rvalid; all outputs 0; first conflict after release goes to fetch.
- CNT_BITS=2, continuous dual requests for 6 cycles → stall_cnt reads 1,2,3,3,3,3.
